wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Write-back side of the architectural register file. Collects completed results from NSRC
//  functional units over valid/ready channels and grants one per cycle, round-robin.
//  Registers the granted result onto the regfile write port (wa/wvalid/wd).
//  Keeps a busy bitmap (scoreboard) of destinations reserved at issue and not yet written,
//  which the issue stage uses for RAW hazard stalls.
// PARAMETERS
//  NSRC   3   number of result sources (functional units); 2..8
//  AW     5   register address width (32 registers)
//  DW     64  register data width
// PORTS
//  clk        in   1         clock, all state on posedge
//  reset      in   1         asynchronous, active-high reset
//  src_valid  in   NSRC      source i holds a result
//  src_ready  out  NSRC      source i granted this cycle (combinational)
//  src_addr   in   NSRC*AW   destination register of source i
//  src_data   in   NSRC*DW   result data of source i
//  rsv_valid  in   1         issue stage reserves a destination this cycle
//  rsv_addr   in   AW        destination being reserved
//  busy       out  32        bit r = 1: register r reserved, write-back pending
//  wa         out  AW        regfile write address
//  wvalid     out  1         regfile write enable
//  wd         out  DW        regfile write data
//  err        out  1         sticky: a write-back hit a register that was not busy
// BEHAVIOUR
//  Reset (async assert): wvalid=0, wa=0, wd=0, busy=0, err=0, rr_ptr=0, src_ready=0 while reset.
//  Arbitration (combinational):
//   - scan sources rr_ptr, rr_ptr+1, ... mod NSRC; first with src_valid=1 gets src_ready=1.
//   - at most one src_ready bit is high. All low when no src_valid is high.
//   - src_ready never depends on the source's own data.
//  Transfer: src_valid[i] & src_ready[i] at a posedge. The source holds valid/addr/data until then.
//  rr_ptr: after a transfer from i, rr_ptr <= (i+1) mod NSRC; otherwise it holds.
//  Output register, latency 1 cycle:
//   - on a transfer: wa<=src_addr[i], wd<=src_data[i], wvalid<=(src_addr[i]!=0).
//   - no transfer: wvalid<=0; wa/wd hold their last value.
//   - a transfer to x0 is accepted (source is released), but produces no regfile write.
//  busy bitmap, updated at each posedge:
//   - set: busy[rsv_addr]<=1 if rsv_valid & rsv_addr!=0.
//   - clear: busy[wa]<=0 if wvalid=1, so it drops at the same edge the regfile commits.
//   - set and clear on the same register at the same edge: set wins (new reservation).
//   - busy[0] is constantly 0. Re-reserving a busy register keeps it at 1; no counting.
//  err: set at the edge where wvalid=1 and busy[wa]=0. Cleared only by reset.
//  Reset mid-operation: a pending output write is dropped (wvalid=0) and all reservations are lost.
//  Throughput: one write-back per cycle. No internal buffering beyond the output register.
// TESTING
//  1. Reset: reset=1 mid-stream with src_valid=3'b111 -> wvalid=0, busy=0, src_ready=0,
//     err=0 immediately (no clock edge needed).
//  2. Single write: rsv x5, then src0 {addr=5, data=64'hDEAD} ->
//     busy[5]=1; next cycle wa=5, wd=DEAD, wvalid=1; busy[5]=0 one edge later.
//  3. Round-robin: src_valid=3'b111 held for 6 cycles (each source re-presents after its grant) ->
//     grant order 0,1,2,0,1,2, exactly one src_ready per cycle.
//  4. x0 write: src1 addr=0 -> src_ready[1]=1, next cycle wvalid=0, busy unchanged, err=0.
//  5. Same-edge collision: wvalid=1 for wa=7 while rsv_valid with rsv_addr=7 -> busy[7]=1 afterwards.
//  6. Unreserved write: src2 addr=9 with busy[9]=0 -> err=1 one cycle after wvalid; it stays 1 until reset.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin grant across NSRC result sources, registered regfile
// write port, and a busy scoreboard of reserved-but-unwritten destinations.
module wb_arbiter #(
    parameter int NSRC = 3,
    parameter int AW   = 5,
    parameter int DW   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC-1:0]      src_valid,
    output logic [NSRC-1:0]      src_ready,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic [NSRC*DW-1:0]   src_data,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic [31:0]          busy,
    output logic [AW-1:0]        wa,
    output logic                 wvalid,
    output logic [DW-1:0]        wd,
    output logic                 err
);
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [PW-1:0]   r_ptr;
    logic [AW-1:0]   r_wa;
    logic [DW-1:0]   r_wd;
    logic            r_wvalid;
    logic [31:0]     r_busy;
    logic            r_err;

    logic [NSRC-1:0] w_ready;
    logic [PW-1:0]   w_gnt;
    logic            w_found;
    logic            w_xfer;
    logic [PW-1:0]   w_ptr_nxt;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;
    logic [31:0]     w_busy_nxt;

    // Scan from the round-robin pointer; only valids are looked at, never data.
    always_comb begin : p_arb
        int idx;
        idx     = 0;
        w_ready = '0;
        w_gnt   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            idx = (int'(r_ptr) + k) % NSRC;
            if (!w_found && src_valid[idx]) begin
                w_found      = 1'b1;
                w_gnt        = idx[PW-1:0];
                w_ready[idx] = 1'b1;
            end
        end
    end

    assign src_ready  = reset ? '0 : w_ready;
    assign w_xfer     = |src_ready;
    assign w_ptr_nxt  = (w_gnt == PW'(NSRC-1)) ? '0 : w_gnt + 1'b1;
    assign w_sel_addr = src_addr[w_gnt*AW +: AW];
    assign w_sel_data = src_data[w_gnt*DW +: DW];

    // Clear on commit first so a same-edge reservation of that register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wvalid)
            w_busy_nxt[r_wa] = 1'b0;
        if (rsv_valid && rsv_addr != '0)
            w_busy_nxt[rsv_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_wa     <= '0;
            r_wd     <= '0;
            r_wvalid <= 1'b0;
            r_busy   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_ptr    <= w_ptr_nxt;
                r_wa     <= w_sel_addr;
                r_wd     <= w_sel_data;
                r_wvalid <= (w_sel_addr != '0);
            end else begin
                r_wvalid <= 1'b0;
            end
            r_busy <= w_busy_nxt;
            if (r_wvalid && !r_busy[r_wa])
                r_err <= 1'b1;
        end
    end

    assign busy   = r_busy;
    assign wa     = r_wa;
    assign wd     = r_wd;
    assign wvalid = r_wvalid;
    assign err    = r_err;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + randomized bench for wb_arbiter against a bit-level scoreboard model.
module tb_wb_arbiter;
    localparam int N = 3;

    logic          clk, reset;
    logic [N-1:0]  src_valid, src_ready;
    logic [N*5-1:0] src_addr;
    logic [N*64-1:0] src_data;
    logic          rsv_valid;
    logic [4:0]    rsv_addr;
    logic [31:0]   busy;
    logic [4:0]    wa;
    logic          wvalid;
    logic [63:0]   wd;
    logic          err;

    wb_arbiter #(.NSRC(N), .AW(5), .DW(64)) dut (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(src_ready),
        .src_addr(src_addr), .src_data(src_data), .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr), .busy(busy), .wa(wa), .wvalid(wvalid), .wd(wd), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: pending source requests plus architectural state.
    bit          v[N];
    logic [4:0]  a[N];
    logic [63:0] d[N];
    int          m_ptr;
    logic [31:0] m_busy;
    logic [4:0]  m_wa;
    logic [63:0] m_wd;
    bit          m_wv, m_err;
    int          last_g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            src_valid[i]          = v[i];
            src_addr[i*5 +: 5]    = a[i];
            src_data[i*64 +: 64]  = d[i];
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_busy = '0; m_wa = '0; m_wd = '0; m_wv = 0; m_err = 0;
        for (int i = 0; i < N; i++) v[i] = 0;
    endtask

    task automatic check_outs(input string pfx);
        chk({pfx, "_wvalid"}, 64'(wvalid), 64'(m_wv));
        chk({pfx, "_wa"}, 64'(wa), 64'(m_wa));
        chk({pfx, "_wd"}, wd, m_wd);
        chk({pfx, "_busy"}, 64'(busy), 64'(m_busy));
        chk({pfx, "_err"}, 64'(err), 64'(m_err));
    endtask

    // One clock: inputs are applied, grant checked before the edge, outputs after.
    task automatic cycle(input string pfx);
        int g;
        logic [N-1:0] er;
        g = -1;
        drive();
        #1;
        for (int k = 0; k < N; k++)
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk({pfx, "_ready"}, 64'(src_ready), 64'(er));
        @(posedge clk);
        if (m_wv && !m_busy[m_wa]) m_err = 1;
        if (m_wv) m_busy[m_wa] = 0;
        if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1;
        if (g >= 0) begin
            m_wa = a[g]; m_wd = d[g]; m_wv = (a[g] != 0);
            m_ptr = (g + 1) % N; v[g] = 0;
        end else begin
            m_wv = 0;
        end
        last_g = g;
        #1;
        rsv_valid = 0;
        check_outs(pfx);
    endtask

    // Asynchronous reset raised mid-cycle while every source is requesting.
    task automatic mid_reset(input string pfx);
        for (int i = 0; i < N; i++) v[i] = 1;
        drive();
        #2;
        reset = 1;
        #1;
        model_reset();
        chk({pfx, "_rst_ready"}, 64'(src_ready), 64'd0);
        check_outs({pfx, "_rst"});
        @(posedge clk);
        #1;
        reset = 0;
        drive();
    endtask

    function automatic logic [4:0] pick_addr();
        int s;
        s = $urandom_range(0, 31);
        if ($urandom_range(0, 9) < 8)
            for (int k = 0; k < 32; k++)
                if (m_busy[(s + k) % 32]) return 5'((s + k) % 32);
        return 5'(s);
    endfunction

    initial begin
        reset = 1; rsv_valid = 0; rsv_addr = '0;
        for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
        model_reset();
        drive();
        @(posedge clk); #1;
        chk("init_ready", 64'(src_ready), 64'd0);
        check_outs("init");
        reset = 0;

        // Single reserved write to x5.
        rsv_valid = 1; rsv_addr = 5;
        cycle("t2_rsv");
        chk("t2_busy5_set", 64'(busy[5]), 64'd1);
        v[0] = 1; a[0] = 5; d[0] = 64'hDEAD;
        cycle("t2_wr");
        chk("t2_wv", 64'(wvalid), 64'd1);
        chk("t2_wd", wd, 64'hDEAD);
        chk("t2_busy5_hold", 64'(busy[5]), 64'd1);
        cycle("t2_idle");
        chk("t2_busy5_clr", 64'(busy[5]), 64'd0);

        // x0 write is accepted but commits nothing.
        v[1] = 1; a[1] = 0; d[1] = 64'h1234;
        cycle("t4_x0");
        chk("t4_wv", 64'(wvalid), 64'd0);
        chk("t4_err", 64'(err), 64'd0);

        // Reservation and commit of x7 on the same edge: set wins.
        rsv_valid = 1; rsv_addr = 7;
        cycle("t5_rsv");
        v[0] = 1; a[0] = 7; d[0] = 64'h77;
        cycle("t5_wr");
        rsv_valid = 1; rsv_addr = 7;
        cycle("t5_coll");
        chk("t5_busy7", 64'(busy[7]), 64'd1);
        chk("t5_err", 64'(err), 64'd0);

        // Write to an unreserved register raises sticky err.
        v[2] = 1; a[2] = 9; d[2] = 64'h99;
        cycle("t6_wr");
        chk("t6_err_pre", 64'(err), 64'd0);
        cycle("t6_flag");
        chk("t6_err", 64'(err), 64'd1);
        cycle("t6_sticky");
        chk("t6_err_sticky", 64'(err), 64'd1);

        // Round-robin with all sources continuously requesting.
        for (int i = 0; i < N; i++) begin v[i] = 1; a[i] = 5'(10 + i); d[i] = 64'(i); end
        for (int k = 0; k < 6; k++) begin
            cycle("t3_rr");
            chk("t3_order", 64'(last_g), 64'(k % N));
            v[last_g] = 1; d[last_g] = d[last_g] + 64'd3;
        end
        mid_reset("t3");

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < N; i++)
                if (!v[i] && $urandom_range(0, 99) < 60) begin
                    v[i] = 1; a[i] = pick_addr(); d[i] = {$urandom, $urandom};
                end
            rsv_valid = ($urandom_range(0, 1) == 1);
            rsv_addr  = 5'($urandom_range(0, 31));
            cycle("rnd");
            if (n % 100 == 99) mid_reset("rnd");
        end

        // Final reset mid-stream with all sources valid.
        for (int i = 0; i < N; i++) begin v[i] = 1; a[i] = 5'(20 + i); end
        rsv_valid = 1; rsv_addr = 20;
        cycle("t1_pre");
        mid_reset("t1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
